// File: rtl/line_window_if.sv
// ============================================================================
// Module   : line_window_if
// Purpose  : Pixel-source handshake plus window/status outputs of line_window_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_window_if #(
    parameter int CW = 10,
    parameter int RW = 9
) ();
    logic          start;
    logic          in_valid;
    logic [16:0]   in_pixel;
    logic          in_ready;
    logic [16:0]   sr_in;
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          border;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, in_valid, in_pixel,
        input  in_ready, sr_in, win_valid, win_col, win_row, border, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_pixel,
        output in_ready, sr_in, win_valid, win_col, win_row, border, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/line_window_ctrl.sv
// ============================================================================
// Module   : line_window_ctrl
// Purpose  : Frame sequencer feeding a 3x3 stencil line-buffer chain; tags window centres.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_window_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 10,
    parameter int RW     = 9
) (
    input  wire logic   clk,
    input  wire logic   rst,
    line_window_if.slave bus
);

    localparam int             PW          = $clog2(WIDTH*HEIGHT + WIDTH + 1);
    localparam logic [PW-1:0]  C_LAST_PIX  = PW'(WIDTH*HEIGHT - 1);
    localparam logic [PW-1:0]  C_LAST_PUSH = PW'(WIDTH*HEIGHT + WIDTH);
    localparam logic [PW-1:0]  C_FIRST_WIN = PW'(WIDTH + 1);
    localparam logic [CW-1:0]  C_COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0]  C_ROW_LAST  = RW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_in_ready;
    logic          w_busy;
    logic          w_done;

    logic [PW-1:0] r_p;
    logic [16:0]   r_sr;
    logic          r_wv;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_border;
    logic          r_err;

    logic          w_start_ok;
    logic          w_push;
    logic          w_win;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_border;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                // No stall path exists downstream, so a gap in the source is fatal.
                if (!bus.in_valid)             w_next = S_ERR;
                else if (r_p == C_LAST_PIX)    w_next = S_FLUSH;
            end
            S_FLUSH: begin
                w_busy = 1'b1;
                if (r_p == C_LAST_PUSH) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR:   if (bus.start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_ERR);
    assign w_push     = (r_state == S_RUN && bus.in_valid) || (r_state == S_FLUSH);
    assign w_win      = w_push && (r_p >= C_FIRST_WIN);

    // Centre of the push being registered now: first window is (0,0), then raster step.
    always_comb begin
        w_col = r_col;
        w_row = r_row;
        if (r_p == C_FIRST_WIN) begin
            w_col = '0;
            w_row = '0;
        end else if (r_col == C_COL_LAST) begin
            w_col = '0;
            w_row = r_row + 1'b1;
        end else begin
            w_col = r_col + 1'b1;
        end
    end

    assign w_border = (w_row == '0) || (w_row == C_ROW_LAST) ||
                      (w_col == '0) || (w_col == C_COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p      <= '0;
            r_sr     <= '0;
            r_wv     <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
            r_border <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_p   <= '0;
                r_col <= '0;
                r_row <= '0;
                r_err <= 1'b0;
            end
            if (w_push) begin
                r_sr     <= (r_state == S_RUN) ? bus.in_pixel : 17'd0;
                r_p      <= r_p + 1'b1;
                r_wv     <= w_win;
                r_border <= w_win & w_border;
                if (w_win) begin
                    r_col <= w_col;
                    r_row <= w_row;
                end
            end else begin
                r_sr     <= '0;
                r_wv     <= 1'b0;
                r_border <= 1'b0;
            end
            if (r_state == S_RUN && !bus.in_valid) r_err <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.sr_in     = r_sr;
    assign bus.win_valid = r_wv;
    assign bus.win_col   = r_col;
    assign bus.win_row   = r_row;
    assign bus.border    = r_border;
    assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_line_window_ctrl.sv
// ============================================================================
// Module   : tb_line_window_ctrl
// Purpose  : Scoreboard bench for line_window_ctrl with a small 4x3 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_window_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 3;
    localparam int RW = 2;

    typedef struct {
        int sr;
        int wv;
        int col;
        int row;
        int bd;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    line_window_if #(.CW(CW), .RW(RW)) bus ();

    line_window_ctrl #(.WIDTH(W), .HEIGHT(H), .CW(CW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the chain sees the frame's pixels then W+1 zeros; push p
    // carries a window centre at raster index p-W-1 once p reaches W+1.
    task automatic enqueue_frame(input int pix[], input int n_push);
        for (int p = 0; p < n_push; p++) begin
            exp_t e;
            int   c;
            e.sr = (p < W*H) ? pix[p] : 0;
            e.wv = (p >= W + 1) ? 1 : 0;
            c    = p - W - 1;
            e.col = e.wv ? c % W : 0;
            e.row = e.wv ? c / W : 0;
            e.bd  = e.wv && (e.row == 0 || e.row == H-1 || e.col == 0 || e.col == W-1) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: a push registered at a clock edge is visible until the next edge.
    initial begin
        bit   pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sr_in", int'(bus.sr_in), e.sr);
                        chk("win_valid", int'(bus.win_valid), e.wv);
                        chk("border", int'(bus.border), e.bd);
                        if (e.wv != 0) begin
                            chk("win_col", int'(bus.win_col), e.col);
                            chk("win_row", int'(bus.win_row), e.row);
                        end
                    end
                end else begin
                    chk("idle_sr_in", int'(bus.sr_in), 0);
                    chk("idle_win_valid", int'(bus.win_valid), 0);
                end
                pend = (bus.in_ready && bus.in_valid) || (bus.busy && !bus.in_ready);
            end
        end
    end

    // mode 0: clean frame, 1: underrun at pixel drop_at, 2: async reset mid-flush.
    // Called at posedge+1 with the DUT in IDLE or ERR; start is raised immediately.
    task automatic run_frame(input int mode, input int drop_at, input bit poke, input bit ramp);
        int pix[];
        int rdy;
        int fl;
        int c;
        int n_push;
        pix = new[W*H];
        for (int i = 0; i < W*H; i++) pix[i] = ramp ? i + 1 : int'(17'($urandom));
        n_push = (mode == 1) ? drop_at : W*H + W + 1;
        enqueue_frame(pix, n_push);

        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("run_err_clear", int'(bus.err), 0);
        chk("run_ready", int'(bus.in_ready), 1);

        rdy = 0;
        for (int i = 0; i < W*H; i++) begin
            if (bus.in_ready) rdy++;
            bus.in_pixel = 17'(pix[i]);
            bus.in_valid = !(mode == 1 && i == drop_at);
            bus.start    = poke && (i == W*H/2);
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (mode == 1 && i == drop_at) begin
                bus.in_valid = 1'b0;
                chk("uf_in_ready", int'(bus.in_ready), 0);
                chk("uf_err", int'(bus.err), 1);
                chk("uf_sr_in", int'(bus.sr_in), 0);
                chk("uf_busy", int'(bus.busy), 0);
                return;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_pixel = 17'($urandom);
        chk("ready_cycles", rdy, W*H);

        fl = 0;
        for (c = 0; c < W + 6; c++) begin
            if (bus.done) break;
            if (bus.busy && !bus.in_ready) fl++;
            if (mode == 2 && c == 2) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_outputs", int'({bus.sr_in, bus.win_valid, bus.win_col, bus.win_row,
                                         bus.border, bus.busy, bus.done, bus.err, bus.in_ready}), 0);
                exp_q.delete();
                @(negedge clk); #1 rst = 1'b0;
                rdy = 0;
                for (int k = 0; k < 12; k++) begin
                    @(posedge clk); #1;
                    if (bus.done || bus.busy) rdy++;
                end
                chk("rst_no_done", rdy, 0);
                return;
            end
            @(posedge clk); #1;
        end
        chk("done_latency", c, W + 1);
        chk("flush_cycles", fl, W + 1);
        chk("done_busy", int'(bus.busy), 0);
        chk("done_sr_in", int'(bus.sr_in), 0);
        bus.start = poke;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("done_pulse_width", int'(bus.done), 0);
        chk("idle_in_ready", int'(bus.in_ready), 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({bus.sr_in, bus.win_valid, bus.win_col, bus.win_row,
                                   bus.border, bus.busy, bus.done, bus.err, bus.in_ready}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(0, -1, 1'b1, 1'b1);
        run_frame(0, -1, 1'b0, 1'b0);
        run_frame(1, 6, 1'b0, 1'b1);
        run_frame(0, -1, 1'b0, 1'b1);
        run_frame(2, -1, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int f = 0; f < 8; f++) begin
            int m;
            m = int'($urandom_range(0, 2));
            run_frame(m, int'($urandom_range(0, W*H-1)), 1'($urandom), 1'b0);
            if (m == 2) begin
                @(posedge clk); #1;
            end
        end
        run_frame(0, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
